ff_bank_readback: RTL

Readback engine for a bank of enable/set/reset flop models. It snapshots the parallel Q outputs of a WIDTH-bit flop bank and streams them out serially over a valid/ready link for test and debug observation. It is the read side of the flop bank: load logic writes the flops, and this block reads them back without disturbing them.

---
 rtl/ff_readback_pkg.sv | 17 +
 rtl/ff_readback_shreg.sv | 42 ++++
 rtl/ff_bank_readback.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ff_readback_pkg.sv
// Shared state encoding and sizing helpers for the flop-bank readback engine.
package ff_readback_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned width);
    return int'($clog2(width));
  endfunction

endpackage

// File: rtl/ff_readback_shreg.sv
// Shadow register for one readback frame: parallel load, then zero-filling shift
// so the presented bit returns to 0 once every bit has been streamed out.
module ff_readback_shreg #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             E,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             out
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d = d;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
      end else begin
        shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      shadow_q <= '0;
    end else if (E) begin
      shadow_q <= shadow_d;
    end
  end

  assign out = MSB_FIRST ? shadow_q[WIDTH-1] : shadow_q[0];

endmodule

// File: rtl/ff_bank_readback.sv
// Snapshots a flop bank's Q outputs and streams them serially over valid/ready,
// framed by ser_last and followed by a one-cycle done pulse.
module ff_bank_readback
  import ff_readback_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             E,
  input  logic             start,
  input  logic [WIDTH-1:0] q_bus,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W      = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_c;
  logic             shift_c;
  logic             xfer_c;

  assign xfer_c = E & valid_q & ser_ready;

  // Next-state and registered-output logic; E=0 leaves every default (hold) in place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    if (E) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CAPTURE;
            busy_d  = 1'b1;
          end
        end
        CAPTURE: begin
          load_c  = 1'b1;
          cnt_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (xfer_c) begin
            shift_c = 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
              last_d = (cnt_q == CNT_PENULT);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ff_readback_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (clk),
    .R    (R),
    .E    (E),
    .load (load_c),
    .shift(shift_c),
    .d    (q_bus),
    .out  (ser_data)
  );

  assign ser_valid = valid_q;
  assign ser_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
